led_matrix_column_scanner: RTL and testbench

- Sequential driver that consumes the 5x7 irrigation-status image produced by the per-column status decoders and multiplexes it onto the physical LED matrix.
- Scans one column at a time: a blanking interval, then a drive interval showing that column's 7 row bits.
- Latches a full-frame snapshot at each frame start so decoder changes never tear a frame.
- Sits between the column decoders and the matrix pins.

---
 rtl/led_matrix_pkg.sv | 31 +++
 rtl/led_matrix_column_scanner_if.sv | 25 ++
 rtl/led_matrix_phase_counter.sv | 50 +++++
 rtl/led_matrix_column_scanner.sv | 84 ++++++++
 tb/tb_led_matrix_column_scanner.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants, types and helpers for the LED matrix scan path.
// The irrigation status codes are the values the column decoders render.
package led_matrix_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;
    localparam int IMG_W    = NUM_COLS * NUM_ROWS;
    localparam int COL_W    = 3;

    localparam logic [NUM_COLS-1:0] COL_OFF = 5'b11111;

    typedef enum logic [1:0] {
        IRR_IDLE     = 2'd0,
        IRR_WATERING = 2'd1,
        IRR_DRY      = 2'd2,
        IRR_FAULT    = 2'd3
    } irr_status_t;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_t;

    function automatic logic [NUM_ROWS-1:0] column_slice(
        input logic [IMG_W-1:0] img,
        input logic [COL_W-1:0] c
    );
        return img[c*NUM_ROWS +: NUM_ROWS];
    endfunction

endpackage

// File: rtl/led_matrix_column_scanner_if.sv
// Bundle between the status decoders / matrix pins (master) and the scanner (slave).
// No valid/ready here: enable is a level, frame_image is sampled only on frame start.
interface led_matrix_column_scanner_if;
    import led_matrix_pkg::*;

    logic                enable;
    logic [IMG_W-1:0]    frame_image;
    logic [NUM_COLS-1:0] columns;
    logic [NUM_ROWS-1:0] rows;
    logic [COL_W-1:0]    col_index;
    logic                frame_start;
    scan_state_t         state;
    logic [7:0]          phase;

    modport master (
        output enable, frame_image,
        input  columns, rows, col_index, frame_start, state, phase
    );

    modport slave (
        input  enable, frame_image,
        output columns, rows, col_index, frame_start, state, phase
    );

endinterface

// File: rtl/led_matrix_phase_counter.sv
// Phase/column counters for the scan; they hold the position the next edge will display.
// Dropping enable parks both counters at the frame start position.
module led_matrix_phase_counter
    import led_matrix_pkg::*;
#(
    parameter int BLANK_CYCLES = 2,
    parameter int DRIVE_CYCLES = 4,
    localparam int PH_MAX = BLANK_CYCLES + DRIVE_CYCLES - 1,
    localparam int PH_W   = $clog2(BLANK_CYCLES + DRIVE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [PH_W-1:0]  ph,
    output logic [COL_W-1:0] col,
    output logic             in_drive,
    output logic             frame_tick
);

    logic [PH_W-1:0]  ph_nxt;
    logic [COL_W-1:0] col_nxt;

    always_comb begin
        ph_nxt  = ph;
        col_nxt = col;
        if (!enable) begin
            ph_nxt  = '0;
            col_nxt = '0;
        end else if (ph == PH_W'(PH_MAX)) begin
            ph_nxt  = '0;
            col_nxt = (col == COL_W'(NUM_COLS - 1)) ? '0 : col + COL_W'(1);
        end else begin
            ph_nxt = ph + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph  <= '0;
            col <= '0;
        end else begin
            ph  <= ph_nxt;
            col <= col_nxt;
        end
    end

    assign in_drive   = (ph >= PH_W'(BLANK_CYCLES));
    assign frame_tick = enable && (ph == '0) && (col == '0);

endmodule

// File: rtl/led_matrix_column_scanner.sv
// Multiplexes a 5x7 status image onto the LED matrix one column at a time, with a
// blanking gap before each column and a frame snapshot so the image never tears.
module led_matrix_column_scanner
    import led_matrix_pkg::*;
#(
    parameter int BLANK_CYCLES = 2,
    parameter int DRIVE_CYCLES = 4
) (
    input logic clk,
    input logic rst_n,
    led_matrix_column_scanner_if.slave bus
);

    localparam int PH_W = $clog2(BLANK_CYCLES + DRIVE_CYCLES);

    logic [PH_W-1:0]     ph;
    logic [COL_W-1:0]    col;
    logic                in_drive;
    logic                frame_tick;
    logic [IMG_W-1:0]    shadow;

    scan_state_t         state_nxt;
    logic [NUM_COLS-1:0] columns_nxt;
    logic [NUM_ROWS-1:0] rows_nxt;
    logic [COL_W-1:0]    col_index_nxt;
    logic [7:0]          phase_nxt;

    led_matrix_phase_counter #(
        .BLANK_CYCLES (BLANK_CYCLES),
        .DRIVE_CYCLES (DRIVE_CYCLES)
    ) u_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (bus.enable),
        .ph         (ph),
        .col        (col),
        .in_drive   (in_drive),
        .frame_tick (frame_tick)
    );

    // Outputs are computed from the position the counters are about to leave, then
    // registered, so pins always match the registered col_index/phase.
    always_comb begin
        state_nxt     = SCAN_BLANK;
        columns_nxt   = COL_OFF;
        rows_nxt      = '0;
        col_index_nxt = '0;
        phase_nxt     = '0;
        if (bus.enable) begin
            col_index_nxt = col;
            phase_nxt     = 8'(ph);
            if (in_drive) begin
                state_nxt = SCAN_DRIVE;
            end
        end
        if (state_nxt == SCAN_DRIVE) begin
            columns_nxt = ~(NUM_COLS'(1) << col);
            rows_nxt    = column_slice(shadow, col);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.columns     <= COL_OFF;
            bus.rows        <= '0;
            bus.col_index   <= '0;
            bus.frame_start <= 1'b0;
            bus.state       <= SCAN_BLANK;
            bus.phase       <= '0;
            shadow          <= '0;
        end else begin
            bus.columns     <= columns_nxt;
            bus.rows        <= rows_nxt;
            bus.col_index   <= col_index_nxt;
            bus.frame_start <= frame_tick;
            bus.state       <= state_nxt;
            bus.phase       <= phase_nxt;
            if (frame_tick) begin
                shadow <= bus.frame_image;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Bench for led_matrix_column_scanner: frame timing, image content, tear-free
// snapshot, enable drop, async reset, and a randomized exclusivity sweep.
module tb_led_matrix_column_scanner;
    import led_matrix_pkg::*;

    typedef struct {
        int         cyc;
        logic [4:0] cols;
        logic [6:0] rows;
        logic [2:0] idx;
        logic       fs;
    } vec_t;

    localparam int NVEC = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t tbl [NVEC];
    logic [6:0] col_img [NUM_COLS];

    led_matrix_column_scanner_if bus ();
    led_matrix_column_scanner_if bus2 ();

    led_matrix_column_scanner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    led_matrix_column_scanner #(
        .BLANK_CYCLES (1),
        .DRIVE_CYCLES (1)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_image();
        bus.frame_image = {col_img[4], col_img[3], col_img[2], col_img[1], col_img[0]};
    endtask

    function automatic logic [15:0] outs();
        return {bus.columns, bus.rows, bus.col_index, bus.frame_start};
    endfunction

    // Expected outputs of the main run, cycle 0 = first edge after reset release.
    // Column 0 image changes at cycle 10; enable is low for the edges of cycles 81, 82.
    function automatic logic [15:0] exp_at(input int t);
        int tt, p, c, ph;
        logic [4:0] cs;
        logic [6:0] r;
        if (t == 81 || t == 82) return {5'h1f, 7'h00, 3'd0, 1'b0};
        tt = (t < 81) ? t : t - 83;
        p  = tt % 30;
        c  = p / 6;
        ph = p % 6;
        if (ph < 2) begin
            cs = 5'h1f;
            r  = 7'h00;
        end else begin
            cs = ~(5'd1 << c);
            if (c == 0) r = ((t - p) > 10) ? 7'h7f : 7'h41;
            else        r = 7'(1 << c) | 7'h40;
        end
        return {cs, r, 3'(c), (p == 0)};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;

        tbl[0]  = '{0,  5'h1f, 7'h00, 3'd0, 1'b1};
        tbl[1]  = '{1,  5'h1f, 7'h00, 3'd0, 1'b0};
        tbl[2]  = '{2,  5'h1e, 7'h41, 3'd0, 1'b0};
        tbl[3]  = '{5,  5'h1e, 7'h41, 3'd0, 1'b0};
        tbl[4]  = '{6,  5'h1f, 7'h00, 3'd1, 1'b0};
        tbl[5]  = '{8,  5'h1d, 7'h42, 3'd1, 1'b0};
        tbl[6]  = '{14, 5'b11011, 7'b1000100, 3'd2, 1'b0};
        tbl[7]  = '{26, 5'b01111, 7'b1010000, 3'd4, 1'b0};
        tbl[8]  = '{30, 5'h1f, 7'h00, 3'd0, 1'b1};
        tbl[9]  = '{32, 5'h1e, 7'h7f, 3'd0, 1'b0};
        tbl[10] = '{60, 5'h1f, 7'h00, 3'd0, 1'b1};
        tbl[11] = '{80, 5'b10111, 7'h48, 3'd3, 1'b0};
        tbl[12] = '{81, 5'h1f, 7'h00, 3'd0, 1'b0};
        tbl[13] = '{83, 5'h1f, 7'h00, 3'd0, 1'b1};
        tbl[14] = '{85, 5'h1e, 7'h7f, 3'd0, 1'b0};
        tbl[15] = '{29, 5'b01111, 7'b1010000, 3'd4, 1'b0};

        for (int c = 0; c < NUM_COLS; c++) col_img[c] = 7'(1 << c) | 7'h40;
        drive_image();
        bus.enable        = 1'b1;
        bus2.enable       = 1'b0;
        bus2.frame_image  = '0;
        rst_n             = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs()), 32'({5'h1f, 7'h00, 3'd0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        // Frame timing, image content, tear-free snapshot, enable drop.
        for (int t = 0; t <= 92; t++) begin
            tick_sample();
            check($sformatf("model_c%0d", t), 32'(outs()), 32'(exp_at(t)));
            for (int k = 0; k < NVEC; k++) begin
                if (tbl[k].cyc == t)
                    check($sformatf("vec_c%0d", t), 32'(outs()),
                          32'({tbl[k].cols, tbl[k].rows, tbl[k].idx, tbl[k].fs}));
            end
            if (t == 10) begin
                col_img[0] = 7'h7f;
                drive_image();
            end
            if (t == 80) bus.enable = 1'b0;
            if (t == 82) bus.enable = 1'b1;
        end

        // Async reset while column 1 is lit: blanks before any edge.
        check("pre_reset_drive", 32'(bus.columns), 32'(5'h1d));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_drive", 32'(outs()), 32'({5'h1f, 7'h00, 3'd0, 1'b0}));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick_sample();
        check("post_reset_frame_start", 32'(outs()), 32'({5'h1f, 7'h00, 3'd0, 1'b1}));
        tick_sample();
        check("post_reset_ph1", 32'(outs()), 32'({5'h1f, 7'h00, 3'd0, 1'b0}));
        tick_sample();
        check("post_reset_drive0", 32'(outs()), 32'({5'h1e, 7'h7f, 3'd0, 1'b0}));

        // Exclusivity sweep on the 1/1 instance with random image and enable.
        begin
            logic       prev_act;
            logic [4:0] prev_cols;
            logic       cur_act;
            logic       sep_ok;
            prev_act  = 1'b0;
            prev_cols = 5'h1f;
            for (int i = 0; i < 2000; i++) begin
                tick_sample();
                cur_act = (bus2.columns != 5'h1f);
                sep_ok  = !(prev_act && cur_act && (prev_cols != bus2.columns));
                check($sformatf("sweep_onecold_%0d", i),
                      32'($countones(~bus2.columns) <= 1), 32'd1);
                check($sformatf("sweep_gap_%0d", i), 32'(sep_ok), 32'd1);
                prev_act  = cur_act;
                prev_cols = bus2.columns;
                bus2.enable      = ($urandom_range(0, 9) != 0);
                bus2.frame_image = 35'({$urandom(), $urandom()});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
